cpu_timing_generator: RTL and testbench
=======================================

Name: cpu_timing_generator

Overview:
- Produces the one-hot instruction timing vector T[11:0] that drives the CPU control decoder (CPUSystem).
- It sits directly upstream of CPUSystem, which uses T[0] and T[1] for the IR fetch halves and the later T bits for execute micro-steps.
- Control logic ends each instruction with T_Reset, which returns the sequence to T0.
- The block also supports stall (hold), halt/resume at instruction boundaries, and a sticky overrun flag.

Parameters:
- NUM_STEPS, 12, number of timing steps; width of T; the maximum count is NUM_STEPS-1.
- CNT_W, 4, width of the binary step counter SC; must satisfy 2^CNT_W >= NUM_STEPS.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- T_Reset  input  1  end-of-instruction from control logic; next step is T0.
- Stall  input  1  holds the current step (e.g. for a memory wait).
- Halt  input  1  request to halt; sampled only in a cycle where T_Reset=1.
- Resume  input  1  leaves the HALTED state.
- T  output  NUM_STEPS  one-hot timing vector; all zeros while halted.
- SC  output  CNT_W  binary step index matching T.
- Fetch  output  1  equals T[0] | T[1].
- Halted  output  1  high in the HALTED state.
- Overrun  output  1  sticky flag; set when the counter wraps without T_Reset.

Behaviour:
- State machine states: RUN and HALTED.
- All outputs are registered or decoded from registers; there is no combinational input-to-output path.
- Reset (synchronous, highest priority):
  - State=RUN, SC=0, T=000000000001, Fetch=1, Halted=0, Overrun=0.
  - Reset mid-instruction discards the current step.
- RUN state, priority per cycle is T_Reset > Stall > advance:
  - T_Reset=1 and Halt=0: SC goes to 0 next cycle (T0). This applies even if Stall=1.
  - T_Reset=1 and Halt=1: next state is HALTED; SC=0; T=0; Halted=1.
  - T_Reset=0 and Stall=1: SC and T hold.
  - Otherwise: SC goes to SC+1. T shifts left by one in the same cycle SC increments.
  - Wrap-around: if SC = NUM_STEPS-1 and no T_Reset/Stall, SC goes to 0 and Overrun is set to 1.
  - Overrun stays set until Reset.
  - T_Reset asserted at T0 keeps SC at 0; this is legal, with no overrun.
- HALTED state:
  - T=0, Fetch=0, SC=0.
  - Stall, T_Reset and Halt are ignored.
  - Resume=1: next state is RUN with T=T0 (SC=0) and Halted=0.
  - Resume in the same cycle as Reset: Reset wins.
- Invariants:
  - In RUN, T is exactly one-hot and T[SC]=1.
  - In HALTED, T=0.
  - Fetch is never high while halted.
- Latency: every input takes effect on the T value presented in the cycle after the sampling edge.

Optional Feature:
- Macro: CPU_TIMING_INSTR_COUNT_EN.
- Defined:
  - Adds output InstrCount (16 bits, reset 0).
  - InstrCount increments by 1 on every cycle where the state is RUN and T_Reset=1, including when it coincides with Halt.
  - InstrCount wraps from 16'hFFFF to 0 with no flag.
  - InstrCount holds while HALTED or stalled without T_Reset.
- Not defined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then 3 free-running cycles -> T=001, 002, 004, 008 (hex); SC=0, 1, 2, 3; Fetch=1, 1, 0, 0.
- At SC=5, assert Stall for 3 cycles, then T_Reset with Stall still high -> T holds 020 for 3 cycles, then T=001 next; Overrun=0.
- Free-run 12 cycles from T0 with no T_Reset -> T reaches 800 (hex) and then 001; Overrun=1 and stays 1 after a later T_Reset; cleared only by Reset.
- At SC=4, assert T_Reset+Halt -> next T=000, Halted=1, Fetch=0; pulse Stall/T_Reset while halted, T stays 000; Resume -> T=001, Halted=0.
- At SC=7, assert Reset together with Stall -> next T=001, SC=0, Overrun=0, Halted=0.
- With CPU_TIMING_INSTR_COUNT_EN defined, complete 3 instructions (T_Reset at SC=2, 5, 0), the last with Halt -> InstrCount=3, holding at 3 while halted.

Source files
------------

// File: rtl/cpu_timing_generator.sv
// cpu_timing_generator
// Produces the one-hot instruction timing vector T for the CPU control decoder.
// Supports stalling on the current step, halting at an instruction boundary,
// resuming from halt and a sticky overrun flag for a counter wrap.
//
// Optional feature: define CPU_TIMING_INSTR_COUNT_EN to add the 16-bit
// InstrCount output, which counts completed instructions.
//
// Ports:
//   Clock      system clock, rising edge
//   Reset      synchronous active-high reset
//   T_Reset    end of instruction; the next step is T0
//   Stall      hold the current step
//   Halt       halt request, honoured only together with T_Reset
//   Resume     leave the HALTED state
//   T          one-hot timing vector, all zeros while halted
//   SC         binary step index matching T
//   Fetch      T[0] | T[1]
//   Halted     high in the HALTED state
//   Overrun    sticky; set when the counter wraps without T_Reset
//   InstrCount completed-instruction count (optional)
module cpu_timing_generator #(
  parameter int unsigned NUM_STEPS = 12,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 T_Reset,
  input  logic                 Stall,
  input  logic                 Halt,
  input  logic                 Resume,
  output logic [NUM_STEPS-1:0] T,
  output logic [CNT_W-1:0]     SC,
  output logic                 Fetch,
  output logic                 Halted,
`ifdef CPU_TIMING_INSTR_COUNT_EN
  output logic [15:0]          InstrCount,
`endif
  output logic                 Overrun
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam logic [NUM_STEPS-1:0] T_FIRST  = NUM_STEPS'(1);
  localparam logic [CNT_W-1:0]     SC_LAST  = CNT_W'(NUM_STEPS - 1);

  logic [0:0]           state;
  logic [0:0]           state_n;
  logic [CNT_W-1:0]     sc_n;
  logic [NUM_STEPS-1:0] t_n;
  logic                 overrun_n;
  logic                 fetch_n;
  logic                 halted_n;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_RUN;
      SC      <= '0;
      T       <= T_FIRST;
      Fetch   <= 1'b1;
      Halted  <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      state   <= state_n;
      SC      <= sc_n;
      T       <= t_n;
      Fetch   <= fetch_n;
      Halted  <= halted_n;
      Overrun <= overrun_n;
    end
  end

  // Next-state logic: T_Reset > Stall > advance while running.
  always_comb begin
    state_n   = state;
    sc_n      = SC;
    t_n       = T;
    overrun_n = Overrun;
    case (state)
      ST_RUN: begin
        if (T_Reset) begin
          sc_n = '0;
          if (Halt) begin
            state_n = ST_HALTED;
            t_n     = '0;
          end else begin
            t_n = T_FIRST;
          end
        end else if (Stall) begin
          sc_n = SC;
          t_n  = T;
        end else if (SC == SC_LAST) begin
          // Ran off the end of the step table without an end-of-instruction.
          sc_n      = '0;
          t_n       = T_FIRST;
          overrun_n = 1'b1;
        end else begin
          sc_n = SC + CNT_W'(1);
          t_n  = T << 1;
        end
      end
      ST_HALTED: begin
        sc_n = '0;
        t_n  = '0;
        if (Resume) begin
          state_n = ST_RUN;
          t_n     = T_FIRST;
        end
      end
      default: begin
        state_n = ST_RUN;
        sc_n    = '0;
        t_n     = T_FIRST;
      end
    endcase
    halted_n = (state_n == ST_HALTED);
    fetch_n  = t_n[0] | t_n[1];
  end

`ifdef CPU_TIMING_INSTR_COUNT_EN
  // Counts every end-of-instruction seen while running, halting ones included.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      InstrCount <= '0;
    end else if ((state == ST_RUN) && T_Reset) begin
      InstrCount <= InstrCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_timing_generator.sv
// tb_cpu_timing_generator
// Directed bench for cpu_timing_generator. Each task drives one scenario and
// compares the packed observation {T, SC, Fetch, Halted, Overrun} with
// hand-computed values one cycle after each sampling edge.
module tb_cpu_timing_generator;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        T_Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        Halt = 1'b0;
  logic        Resume = 1'b0;
  logic [11:0] T;
  logic [3:0]  SC;
  logic        Fetch;
  logic        Halted;
  logic        Overrun;
`ifdef CPU_TIMING_INSTR_COUNT_EN
  logic [15:0] InstrCount;
`endif

  int vectors = 0;
  int miscompares = 0;

  cpu_timing_generator #(.NUM_STEPS(12), .CNT_W(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .T_Reset    (T_Reset),
    .Stall      (Stall),
    .Halt       (Halt),
    .Resume     (Resume),
    .T          (T),
    .SC         (SC),
    .Fetch      (Fetch),
    .Halted     (Halted),
`ifdef CPU_TIMING_INSTR_COUNT_EN
    .InstrCount (InstrCount),
`endif
    .Overrun    (Overrun)
  );

  always #5 Clock = ~Clock;

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    Reset = 1'b0; T_Reset = 1'b0; Stall = 1'b0; Halt = 1'b0; Resume = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] exp [4];
    exp[0] = {12'h001, 4'd0, 1'b1, 1'b0, 1'b0};
    exp[1] = {12'h002, 4'd1, 1'b1, 1'b0, 1'b0};
    exp[2] = {12'h004, 4'd2, 1'b0, 1'b0, 1'b0};
    exp[3] = {12'h008, 4'd3, 1'b0, 1'b0, 1'b0};
    idle_inputs();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      vectors++;
      if ({T, SC, Fetch, Halted, Overrun} !== exp[i]) begin
        miscompares++;
        $display("FAIL reset_run[%0d]: got T=%h SC=%0d F=%b H=%b O=%b want %h",
                 i, T, SC, Fetch, Halted, Overrun, exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    // Starts at SC=3; two advances reach SC=5.
    step(); step();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({T, SC, Overrun} !== {12'h020, 4'd5, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got T=%h SC=%0d O=%b want T=020 SC=5 O=0",
                 i, T, SC, Overrun);
      end
    end
    T_Reset = 1'b1;
    step();
    idle_inputs();
    vectors++;
    if ({T, SC, Fetch, Overrun} !== {12'h001, 4'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_treset: got T=%h SC=%0d F=%b O=%b want T=001 SC=0 F=1 O=0",
               T, SC, Fetch, Overrun);
    end
  endtask

  task automatic test_back_to_back();
    // T_Reset held at T0 keeps the sequence at T0 without overrun.
    T_Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({T, SC, Overrun} !== {12'h001, 4'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL treset_at_t0[%0d]: got T=%h SC=%0d O=%b want T=001 SC=0 O=0",
                 i, T, SC, Overrun);
      end
    end
    idle_inputs();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 11; i++) step();
    vectors++;
    if ({T, SC, Overrun} !== {12'h800, 4'd11, 1'b0}) begin
      miscompares++;
      $display("FAIL last_step: got T=%h SC=%0d O=%b want T=800 SC=11 O=0", T, SC, Overrun);
    end
    step();
    vectors++;
    if ({T, SC, Fetch, Overrun} !== {12'h001, 4'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap: got T=%h SC=%0d F=%b O=%b want T=001 SC=0 F=1 O=1",
               T, SC, Fetch, Overrun);
    end
    step(); step();
    T_Reset = 1'b1;
    step();
    idle_inputs();
    vectors++;
    if ({T, SC, Overrun} !== {12'h001, 4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL overrun_sticky: got T=%h SC=%0d O=%b want T=001 SC=0 O=1", T, SC, Overrun);
    end
    Reset = 1'b1;
    step();
    idle_inputs();
    vectors++;
    if ({T, SC, Overrun} !== {12'h001, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL overrun_clear: got T=%h SC=%0d O=%b want T=001 SC=0 O=0", T, SC, Overrun);
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if ({T, SC} !== {12'h010, 4'd4}) begin
      miscompares++;
      $display("FAIL pre_halt: got T=%h SC=%0d want T=010 SC=4", T, SC);
    end
    T_Reset = 1'b1; Halt = 1'b1;
    step();
    idle_inputs();
    vectors++;
    if ({T, SC, Fetch, Halted} !== {12'h000, 4'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL halt_enter: got T=%h SC=%0d F=%b H=%b want T=000 SC=0 F=0 H=1",
               T, SC, Fetch, Halted);
    end
    Stall = 1'b1; step();
    Stall = 1'b0; T_Reset = 1'b1; step();
    T_Reset = 1'b0; step();
    vectors++;
    if ({T, SC, Fetch, Halted} !== {12'h000, 4'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL halt_hold: got T=%h SC=%0d F=%b H=%b want T=000 SC=0 F=0 H=1",
               T, SC, Fetch, Halted);
    end
    Resume = 1'b1;
    step();
    idle_inputs();
    vectors++;
    if ({T, SC, Fetch, Halted} !== {12'h001, 4'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL resume: got T=%h SC=%0d F=%b H=%b want T=001 SC=0 F=1 H=0",
               T, SC, Fetch, Halted);
    end
    step();
    vectors++;
    if ({T, SC} !== {12'h002, 4'd1}) begin
      miscompares++;
      $display("FAIL post_resume: got T=%h SC=%0d want T=002 SC=1", T, SC);
    end
  endtask

  task automatic test_reset_mid();
    // From SC=1, six advances reach SC=7.
    for (int i = 0; i < 6; i++) step();
    vectors++;
    if ({T, SC} !== {12'h080, 4'd7}) begin
      miscompares++;
      $display("FAIL pre_reset: got T=%h SC=%0d want T=080 SC=7", T, SC);
    end
    Reset = 1'b1; Stall = 1'b1;
    step();
    idle_inputs();
    vectors++;
    if ({T, SC, Fetch, Halted, Overrun} !== {12'h001, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: got T=%h SC=%0d F=%b H=%b O=%b want T=001 SC=0 F=1 H=0 O=0",
               T, SC, Fetch, Halted, Overrun);
    end
  endtask

`ifdef CPU_TIMING_INSTR_COUNT_EN
  task automatic test_instr_count();
    Reset = 1'b1; step(); idle_inputs();
    vectors++;
    if (InstrCount !== 16'd0) begin
      miscompares++;
      $display("FAIL icount_reset: got %0d want 0", InstrCount);
    end
    step(); step();                 // SC=2
    T_Reset = 1'b1; step(); idle_inputs();
    Stall = 1'b1; step(); step(); Stall = 1'b0;
    vectors++;
    if (InstrCount !== 16'd1) begin
      miscompares++;
      $display("FAIL icount_one: got %0d want 1", InstrCount);
    end
    for (int i = 0; i < 5; i++) step();   // SC=5
    T_Reset = 1'b1; step();               // back to SC=0, count 2
    Halt = 1'b1; step(); idle_inputs();   // T_Reset at SC=0 with Halt, count 3
    vectors++;
    if ({InstrCount, Halted} !== {16'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL icount_three: got %0d H=%b want 3 H=1", InstrCount, Halted);
    end
    T_Reset = 1'b1; step(); step(); idle_inputs();
    vectors++;
    if (InstrCount !== 16'd3) begin
      miscompares++;
      $display("FAIL icount_halted: got %0d want 3", InstrCount);
    end
    Resume = 1'b1; step(); idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_stall();
    test_back_to_back();
    test_overrun();
    test_halt();
    test_reset_mid();
`ifdef CPU_TIMING_INSTR_COUNT_EN
    test_instr_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
